// File: rtl/fb_rect_fill_pkg.sv
// fb_pkg: frame-buffer geometry, engine state encoding and address packing shared by fb_rect_fill.
package fb_pkg;
    localparam int X_BITS    = 8;
    localparam int Y_BITS    = 7;
    localparam int ADDR_BITS = X_BITS + Y_BITS;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RD, S_WR, S_DONE} state_t;

    function automatic logic [ADDR_BITS-1:0] fb_pack_addr(input logic [X_BITS-1:0] x, input logic [Y_BITS-1:0] y);
        return {y, x};
    endfunction
endpackage

// File: rtl/fb_rect_fill_if.sv
// fb_rect_fill_if: rectangle command handshake plus frame-buffer port A; master issues commands, slave is the engine.
interface fb_rect_fill_if;
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [fb_pkg::X_BITS-1:0]    cmd_x0;
    logic [fb_pkg::Y_BITS-1:0]    cmd_y0;
    logic [fb_pkg::X_BITS-1:0]    cmd_x1;
    logic [fb_pkg::Y_BITS-1:0]    cmd_y1;
    logic                         cmd_color;
    logic                         cmd_xor;
    logic [fb_pkg::ADDR_BITS-1:0] fb_addr;
    logic                         fb_data;
    logic                         fb_we;
    logic                         fb_rdata;
    logic                         busy;
    logic                         done;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_xor, fb_rdata,
        input  cmd_ready, fb_addr, fb_data, fb_we, busy, done
    );
    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_xor, fb_rdata,
        output cmd_ready, fb_addr, fb_data, fb_we, busy, done
    );
endinterface

// File: rtl/fb_rect_fill_scan_counter.sv
// fb_scan_counter: raster scan over a normalised rectangle; equality compares keep x/y from ever passing their max.
module fb_scan_counter
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [X_BITS-1:0] i_x0,
    input  logic [Y_BITS-1:0] i_y0,
    input  logic [X_BITS-1:0] i_x1,
    input  logic [Y_BITS-1:0] i_y1,
    output logic [X_BITS-1:0] o_x,
    output logic [Y_BITS-1:0] o_y,
    output logic              o_last
);
    logic [X_BITS-1:0] r_xmin, r_xmax, r_x;
    logic [Y_BITS-1:0] r_ymin, r_ymax, r_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_xmin <= '0;
            r_xmax <= '0;
            r_ymin <= '0;
            r_ymax <= '0;
            r_x    <= '0;
            r_y    <= '0;
        end else if (i_load) begin
            r_xmin <= (i_x0 < i_x1) ? i_x0 : i_x1;
            r_xmax <= (i_x0 < i_x1) ? i_x1 : i_x0;
            r_ymin <= (i_y0 < i_y1) ? i_y0 : i_y1;
            r_ymax <= (i_y0 < i_y1) ? i_y1 : i_y0;
            r_x    <= (i_x0 < i_x1) ? i_x0 : i_x1;
            r_y    <= (i_y0 < i_y1) ? i_y0 : i_y1;
        end else if (i_step) begin
            if (r_x != r_xmax) begin
                r_x <= r_x + X_BITS'(1);
            end else begin
                r_x <= r_xmin;
                if (r_y != r_ymax) r_y <= r_y + Y_BITS'(1);
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = (r_x == r_xmax) && (r_y == r_ymax);
endmodule

// File: rtl/fb_rect_fill.sv
// fb_rect_fill: writes every pixel of an axis-aligned rectangle into the 256x128 1-bpp frame buffer, one per cycle.
// Define FB_XOR_EN to add read-modify-write XOR drawing (two cycles per pixel).
module fb_rect_fill
    import fb_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    fb_rect_fill_if.slave bus
);
    state_t            r_state, w_next;
    logic              r_color;
    logic              w_accept, w_step, w_last, w_xor_cmd, w_rdata;
    logic [X_BITS-1:0] w_x;
    logic [Y_BITS-1:0] w_y;

`ifdef FB_XOR_EN
    assign w_xor_cmd = bus.cmd_xor;
    assign w_rdata   = bus.fb_rdata;
`else
    logic w_unused;
    assign w_unused  = bus.cmd_xor ^ bus.fb_rdata;
    assign w_xor_cmd = 1'b0;
    assign w_rdata   = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_step   = (r_state == S_FILL) || (r_state == S_WR);

    fb_scan_counter u_scan (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_accept),
        .i_step (w_step),
        .i_x0   (bus.cmd_x0),
        .i_y0   (bus.cmd_y0),
        .i_x1   (bus.cmd_x1),
        .i_y1   (bus.cmd_y1),
        .o_x    (w_x),
        .o_y    (w_y),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_color <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_color <= bus.cmd_color;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? (w_xor_cmd ? S_RD : S_FILL) : S_IDLE;
            S_FILL:  w_next = w_last ? S_DONE : S_FILL;
            S_RD:    w_next = S_WR;
            S_WR:    w_next = w_last ? S_DONE : S_RD;
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.fb_we     = w_step;
    assign bus.fb_addr   = fb_pack_addr(w_x, w_y);
    // port A read data lands in WR, one cycle after RD presented the address
    assign bus.fb_data   = (r_state == S_FILL) ? r_color : (r_state == S_WR) ? (w_rdata ^ r_color) : 1'b0;
endmodule
